// File: rtl/adc_sequencer_if.sv
// rtl/adc_sequencer_if.sv - ADC pin and tagged sample-stream bundle for adc_sequencer
interface adc_sequencer_if #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_BITS  = 3
);
  logic                  enable;
  logic                  adc_data_out;
  logic                  adc_sync;
  logic                  adc_data_in;
  logic [DATA_WIDTH-1:0] sample_data;
  logic [ADDR_BITS-1:0]  sample_channel;
  logic                  sample_valid;
  logic                  busy;

  modport master (
    output enable, adc_data_out,
    input  adc_sync, adc_data_in, sample_data, sample_channel, sample_valid, busy
  );

  modport slave (
    input  enable, adc_data_out,
    output adc_sync, adc_data_in, sample_data, sample_channel, sample_valid, busy
  );
endinterface

// File: rtl/adc_sequencer.sv
// rtl/adc_sequencer.sv - multi-channel serial ADC sequencer: frame sync, control word out, tagged samples in
module adc_sequencer #(
  parameter int                    DATA_WIDTH    = 12,
  parameter int                    FRAME_BITS    = 16,
  parameter int                    FRAME_PERIOD  = 20,
  parameter int                    CHANNELS      = 8,
  parameter int                    ADDR_BITS     = 3,
  parameter int                    ADDR_LSB      = 10,
  parameter logic [FRAME_BITS-1:0] CTRL_TEMPLATE = 16'h8310,
  parameter logic [15:0]           CHANNEL_MASK  = 16'h00FF
) (
  input  logic           serial_clock,
  input  logic           reset,
  adc_sequencer_if.slave bus
);
  localparam int                    CNT_W    = $clog2(FRAME_PERIOD);
  localparam logic [CNT_W-1:0]      LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(FRAME_PERIOD - 1);
  localparam logic [FRAME_BITS-1:0] TOP_BIT  = {1'b1, {(FRAME_BITS-1){1'b0}}};
  localparam logic [15:0]           LIVE     = 16'((32'd1 << CHANNELS) - 32'd1);
  localparam logic [15:0]           MASKED   = CHANNEL_MASK & LIVE;
  // An empty mask degenerates to channel 0 so the sequencer always has a target.
  localparam logic [15:0]           EFF_MASK = (MASKED == 16'd0) ? 16'd1 : MASKED;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t                state, state_next;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic [FRAME_BITS-1:0] ctrl_word;
  logic [DATA_WIDTH-2:0] shift_reg;
  logic [DATA_WIDTH-1:0] captured;
  logic [ADDR_BITS-1:0]  req_channel, prev_channel, first_channel, next_channel;
  logic [15:0]           probe_first, probe_next;
  int                    idx;
  logic                  found;
  logic                  primer;
  logic                  frame_start, frame_wrap;
  logic                  adc_sync, adc_data_in, busy;
  logic [DATA_WIDTH-1:0] sample_data;
  logic [ADDR_BITS-1:0]  sample_channel;
  logic                  sample_valid;

  assign frame_start = (state == IDLE) && bus.enable;
  assign frame_wrap  = (state == GAP) && (cnt == LAST_CNT) && bus.enable;
  // Only the low DATA_WIDTH received bits survive; the upper ones shift out.
  assign captured    = {shift_reg, bus.adc_data_out};

  always_comb begin
    ctrl_word                           = CTRL_TEMPLATE;
    ctrl_word[FRAME_BITS-1]             = 1'b1;
    ctrl_word[ADDR_LSB +: ADDR_BITS]    = req_channel;
  end

  always_comb begin
    first_channel = '0;
    probe_first   = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      probe_first = EFF_MASK >> i;
      if (probe_first[0]) first_channel = ADDR_BITS'(i);
    end
  end

  always_comb begin
    next_channel = req_channel;
    found        = 1'b0;
    idx          = 0;
    probe_next   = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      idx        = (int'(req_channel) + k) % CHANNELS;
      probe_next = EFF_MASK >> idx;
      if (!found && probe_next[0]) begin
        next_channel = ADDR_BITS'(idx);
        found        = 1'b1;
      end
    end
  end

  always_ff @(posedge serial_clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    adc_sync    = 1'b1;
    adc_data_in = 1'b0;
    busy        = 1'b0;
    case (state)
      IDLE: begin
        if (bus.enable) begin
          state_next = SHIFT;
          cnt_next   = '0;
        end
      end
      SHIFT: begin
        adc_sync    = 1'b0;
        adc_data_in = |(ctrl_word & (TOP_BIT >> cnt));
        busy        = 1'b1;
        cnt_next    = cnt + CNT_W'(1);
        if (cnt == LAST_BIT) state_next = GAP;
      end
      GAP: begin
        busy = 1'b1;
        if (cnt == LAST_CNT) begin
          cnt_next   = '0;
          state_next = bus.enable ? SHIFT : IDLE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // The ADC answers one frame late, so a sample is tagged with the previous frame's address.
  always_ff @(posedge serial_clock) begin
    if (reset) begin
      shift_reg      <= '0;
      sample_data    <= '0;
      sample_channel <= '0;
      sample_valid   <= 1'b0;
      req_channel    <= '0;
      prev_channel   <= '0;
      primer         <= 1'b1;
    end else begin
      sample_valid <= 1'b0;
      if (frame_start) begin
        req_channel <= first_channel;
        primer      <= 1'b1;
      end
      if (frame_wrap) begin
        prev_channel <= req_channel;
        req_channel  <= next_channel;
        primer       <= 1'b0;
      end
      if (state == SHIFT) begin
        shift_reg <= captured[DATA_WIDTH-2:0];
        if ((cnt == LAST_BIT) && !primer) begin
          sample_valid   <= 1'b1;
          sample_data    <= captured;
          sample_channel <= prev_channel;
        end
      end
    end
  end

  assign bus.adc_sync       = adc_sync;
  assign bus.adc_data_in    = adc_data_in;
  assign bus.busy           = busy;
  assign bus.sample_data    = sample_data;
  assign bus.sample_channel = sample_channel;
  assign bus.sample_valid   = sample_valid;
endmodule

// File: tb/tb_adc_sequencer.sv
// tb/tb_adc_sequencer.sv - self-checking bench for adc_sequencer with default and sparse channel masks
module tb_adc_sequencer;
  localparam logic [15:0] MASK_B = 16'h00A5;

  logic        clk          = 1'b0;
  logic        reset        = 1'b1;
  logic        enable       = 1'b0;
  logic        adc_data_out = 1'b0;
  int          tests_run    = 0;
  int          failed       = 0;
  int          bit_idx      = 0;
  logic [15:0] cur_word     = '0;
  logic [15:0] fixed_word   = 16'h0A5C;
  bit          use_fixed    = 1'b0;
  logic [15:0] words[$];
  int          lst_b[$];
  logic [14:0] exp_dc[2];

  always #5 clk = ~clk;

  adc_sequencer_if #(.DATA_WIDTH(12), .ADDR_BITS(3)) if_a ();
  adc_sequencer_if #(.DATA_WIDTH(12), .ADDR_BITS(3)) if_b ();

  assign if_a.enable       = enable;
  assign if_a.adc_data_out = adc_data_out;
  assign if_b.enable       = enable;
  assign if_b.adc_data_out = adc_data_out;

  adc_sequencer dut_a (.serial_clock(clk), .reset(reset), .bus(if_a));
  adc_sequencer #(.CHANNEL_MASK(MASK_B)) dut_b (.serial_clock(clk), .reset(reset), .bus(if_b));

  // Channel addressed in frame f of a run: ascending enabled channels, wrapping.
  function automatic int chan_of(int w, int f);
    if (w == 0) return f % 8;
    return lst_b[f % lst_b.size()];
  endfunction

  function automatic logic [15:0] ctrl_for(int ch);
    logic [15:0] cw;
    cw        = 16'h8310 | 16'h8000;
    cw[12:10] = 3'(ch);
    return cw;
  endfunction

  // Expected {adc_sync, adc_data_in, busy, sample_valid} at cycle c of frame f.
  function automatic logic [3:0] exp_ctl(int w, int f, int c);
    logic [15:0] cw;
    if (c >= 16) return {1'b1, 1'b0, 1'b1, (c == 16) && (f > 0)};
    cw = ctrl_for(chan_of(w, f)) << c;
    return {1'b0, cw[15], 1'b1, 1'b0};
  endfunction

  function automatic logic [3:0] obs_ctl(int w);
    if (w == 0) return {if_a.adc_sync, if_a.adc_data_in, if_a.busy, if_a.sample_valid};
    return {if_b.adc_sync, if_b.adc_data_in, if_b.busy, if_b.sample_valid};
  endfunction

  function automatic logic [14:0] obs_dc(int w);
    if (w == 0) return {if_a.sample_data, if_a.sample_channel};
    return {if_b.sample_data, if_b.sample_channel};
  endfunction

  function automatic logic [11:0] word_low(int f);
    logic [15:0] x;
    if (f >= words.size()) return 12'hxxx;
    x = words[f];
    return x[11:0];
  endfunction

  // Advance one clock, then act as the ADC: a fresh reply word per sync-low burst, MSB first.
  task automatic tick();
    @(posedge clk);
    #1;
    if (if_a.adc_sync === 1'b0) begin
      if (bit_idx == 0) begin
        cur_word = use_fixed ? fixed_word : 16'($urandom);
        words.push_back(cur_word);
      end
      adc_data_out = cur_word[15];
      cur_word     = cur_word << 1;
      bit_idx++;
    end else begin
      bit_idx      = 0;
      adc_data_out = 1'($urandom);
    end
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    words.delete();
    exp_dc[0] = '0;
    exp_dc[1] = '0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      for (int w = 0; w < 2; w++) begin
        tests_run++;
        if ({obs_ctl(w), obs_dc(w)} !== {4'b1000, 15'd0}) begin
          failed++;
          $display("FAIL reset_hold dut%0d cyc=%0d got %b_%h want 1000_0000", w, k, obs_ctl(w), obs_dc(w));
        end
      end
    end
    reset = 1'b0;
    words.delete();
    tick();
    for (int w = 0; w < 2; w++) begin
      tests_run++;
      if (obs_ctl(w) !== exp_ctl(w, 0, 0)) begin
        failed++;
        $display("FAIL reset_release dut%0d got %b want %b", w, obs_ctl(w), exp_ctl(w, 0, 0));
      end
    end
  endtask

  task automatic test_framing();
    logic [3:0] e;
    do_reset();
    enable = 1'b1;
    for (int t = 0; t < 120; t++) begin
      tick();
      for (int w = 0; w < 2; w++) begin
        e = exp_ctl(w, t / 20, t % 20);
        if (e[0]) exp_dc[w] = {word_low(t / 20), 3'(chan_of(w, t / 20 - 1))};
        tests_run++;
        if (obs_ctl(w) !== e) begin
          failed++;
          $display("FAIL framing_ctl dut%0d t=%0d got %b want %b", w, t, obs_ctl(w), e);
        end
        tests_run++;
        if (obs_dc(w) !== exp_dc[w]) begin
          failed++;
          $display("FAIL framing_sample dut%0d t=%0d got %h want %h", w, t, obs_dc(w), exp_dc[w]);
        end
      end
    end
  endtask

  task automatic test_data_capture();
    logic [3:0] e;
    use_fixed = 1'b1;
    do_reset();
    enable = 1'b1;
    for (int t = 0; t < 60; t++) begin
      tick();
      for (int w = 0; w < 2; w++) begin
        e = exp_ctl(w, t / 20, t % 20);
        if (e[0]) exp_dc[w] = {12'hA5C, 3'(chan_of(w, t / 20 - 1))};
        tests_run++;
        if (obs_ctl(w) !== e) begin
          failed++;
          $display("FAIL capture_ctl dut%0d t=%0d got %b want %b", w, t, obs_ctl(w), e);
        end
        tests_run++;
        if (obs_dc(w) !== exp_dc[w]) begin
          failed++;
          $display("FAIL capture_sample dut%0d t=%0d got %h want %h", w, t, obs_dc(w), exp_dc[w]);
        end
      end
    end
    use_fixed = 1'b0;
  endtask

  task automatic test_enable_drop();
    logic [3:0] e;
    do_reset();
    enable = 1'b1;
    for (int t = 0; t < 80; t++) begin
      tick();
      for (int w = 0; w < 2; w++) begin
        e = exp_ctl(w, t / 20, t % 20);
        if (e[0]) exp_dc[w] = {word_low(t / 20), 3'(chan_of(w, t / 20 - 1))};
        tests_run++;
        if ({obs_ctl(w), obs_dc(w)} !== {e, exp_dc[w]}) begin
          failed++;
          $display("FAIL drop_run dut%0d t=%0d got %b_%h want %b_%h", w, t, obs_ctl(w), obs_dc(w), e, exp_dc[w]);
        end
      end
      if (t == 65) enable = 1'b0;
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      for (int w = 0; w < 2; w++) begin
        tests_run++;
        if ({obs_ctl(w), obs_dc(w)} !== {4'b1000, exp_dc[w]}) begin
          failed++;
          $display("FAIL drop_idle dut%0d k=%0d got %b_%h want 1000_%h", w, k, obs_ctl(w), obs_dc(w), exp_dc[w]);
        end
      end
    end
    words.delete();
    enable = 1'b1;
    for (int t = 0; t < 40; t++) begin
      tick();
      for (int w = 0; w < 2; w++) begin
        e = exp_ctl(w, t / 20, t % 20);
        if (e[0]) exp_dc[w] = {word_low(t / 20), 3'(chan_of(w, t / 20 - 1))};
        tests_run++;
        if ({obs_ctl(w), obs_dc(w)} !== {e, exp_dc[w]}) begin
          failed++;
          $display("FAIL drop_restart dut%0d t=%0d got %b_%h want %b_%h", w, t, obs_ctl(w), obs_dc(w), e, exp_dc[w]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] e;
    do_reset();
    enable = 1'b1;
    for (int t = 0; t < 30; t++) begin
      tick();
      for (int w = 0; w < 2; w++) begin
        e = exp_ctl(w, t / 20, t % 20);
        if (e[0]) exp_dc[w] = {word_low(t / 20), 3'(chan_of(w, t / 20 - 1))};
        tests_run++;
        if ({obs_ctl(w), obs_dc(w)} !== {e, exp_dc[w]}) begin
          failed++;
          $display("FAIL midreset_pre dut%0d t=%0d got %b_%h want %b_%h", w, t, obs_ctl(w), obs_dc(w), e, exp_dc[w]);
        end
      end
    end
    reset = 1'b1;
    tick();
    for (int w = 0; w < 2; w++) begin
      tests_run++;
      if ({obs_ctl(w), obs_dc(w)} !== {4'b1000, 15'd0}) begin
        failed++;
        $display("FAIL midreset_abort dut%0d got %b_%h want 1000_0000", w, obs_ctl(w), obs_dc(w));
      end
    end
    reset = 1'b0;
    words.delete();
    exp_dc[0] = '0;
    exp_dc[1] = '0;
    for (int t = 0; t < 40; t++) begin
      tick();
      for (int w = 0; w < 2; w++) begin
        e = exp_ctl(w, t / 20, t % 20);
        if (e[0]) exp_dc[w] = {word_low(t / 20), 3'(chan_of(w, t / 20 - 1))};
        tests_run++;
        if ({obs_ctl(w), obs_dc(w)} !== {e, exp_dc[w]}) begin
          failed++;
          $display("FAIL midreset_restart dut%0d t=%0d got %b_%h want %b_%h", w, t, obs_ctl(w), obs_dc(w), e, exp_dc[w]);
        end
      end
    end
  endtask

  initial begin
    logic [15:0] m;
    for (int i = 0; i < 8; i++) begin
      m = MASK_B >> i;
      if (m[0]) lst_b.push_back(i);
    end
    exp_dc[0] = '0;
    exp_dc[1] = '0;
    test_reset();
    test_framing();
    test_data_capture();
    test_enable_drop();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end
endmodule

// File: doc/adc_sequencer.md
# adc_sequencer

Parametrised multi-channel serial ADC sequencer: generates the ADC frame sync, shifts out a per-frame control word that carries the next channel address, and deserialises the returned conversion. It is a tagged, handshaked sample stream and replaces the fixed single-channel ADC packager plus separate sync generator in the audio path. It sits between the ADC pins and the filter bank, clocked by the ADC serial clock.

## Interface
- DATA_WIDTH, 12, sample width; the low bits of the received frame.
- FRAME_BITS, 16, serial bits per frame (sync-low cycles); FRAME_BITS >= DATA_WIDTH.
- FRAME_PERIOD, 20, clocks per conversion; FRAME_PERIOD >= FRAME_BITS+1.
- CHANNELS, 8, number of ADC channels, 1..16.
- ADDR_BITS, 3, channel address width; 2^ADDR_BITS >= CHANNELS.
- ADDR_LSB, 10, bit position of the address LSB inside the control word.
- CTRL_TEMPLATE, 16'h8310, control word before address insertion.
- CHANNEL_MASK, 8'hFF, bit i = 1 enables channel i.
- serialClock  in  1  sole clock (ADC serial clock); all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run request, sampled at frame boundaries.
- adcDataOut  in  1  serial data from the ADC.
- adcSync  out  1  frame sync, active low.
- adcDataIn  out  1  serial control word to the ADC, MSB first.
- sampleData  out  DATA_WIDTH  last received sample.
- sampleChannel  out  ADDR_BITS  channel that sampleData belongs to.
- sampleValid  out  1  one-cycle strobe: sampleData/sampleChannel new.
- busy  out  1  high while not IDLE.

## Operation
- States: IDLE, SHIFT, GAP. Frame counter c runs 0..FRAME_PERIOD-1. SHIFT covers c = 0..FRAME_BITS-1. GAP covers c = FRAME_BITS..FRAME_PERIOD-1.
- IDLE: adcSync=1, adcDataIn=0, busy=0. If enable=1, the next edge enters SHIFT with c=0 and marks the frame as the primer.
- Control word = CTRL_TEMPLATE with bit FRAME_BITS-1 forced to 1. Bits [ADDR_LSB+ADDR_BITS-1:ADDR_LSB] are replaced by reqChannel.
- SHIFT: adcSync=0 and adcDataIn = ctrl[FRAME_BITS-1-c]. adcDataOut is shifted into a FRAME_BITS register, MSB first, on the edge ending each SHIFT cycle.
- GAP: adcSync=1, adcDataIn=0. At c = FRAME_PERIOD-1:
  - enable=1: the next frame starts (SHIFT, c=0).
  - enable=0: go to IDLE.
  - Mid-frame enable changes are ignored.
- The ADC returns, in frame N, the conversion addressed in frame N-1. prevChannel holds the reqChannel of the prior frame.
- Sample output:
  - On entry to GAP (c = FRAME_BITS), for any frame other than the primer: sampleData = shift[DATA_WIDTH-1:0], sampleChannel = prevChannel, sampleValid=1 for exactly that cycle.
  - Upper FRAME_BITS-DATA_WIDTH received bits are discarded.
  - The primer frame produces no sampleValid.
  - sampleData and sampleChannel hold between strobes.
- Channel sequencing:
  - On leaving IDLE, reqChannel = the lowest enabled channel.
  - Each later frame takes the next enabled channel in ascending order, wrapping past CHANNELS-1.
  - CHANNEL_MASK restricted to CHANNELS bits and all-zero behaves as channel 0 only.
  - A single enabled channel repeats every frame.
- Reset (any state, any c):
  - Next edge: IDLE, c=0, adcSync=1, adcDataIn=0, sampleValid=0, sampleData=0, sampleChannel=0, busy=0.
  - Shift register and sequencing are cleared, and the next start is a primer.

## Timing
- adcSync falls on the first edge with enable=1 in IDLE and stays low exactly FRAME_BITS cycles. Sync low edges repeat every FRAME_PERIOD cycles while enable=1.
- adcDataIn changes on rising edges. The ADC samples it on the falling edge.
- Latency from the last data bit captured to sampleValid: 1 cycle. Latency from frame start to its own sample: FRAME_PERIOD+FRAME_BITS cycles, because of the one-frame pipeline.
- Sample rate = serialClock / FRAME_PERIOD, shared across the enabled channels.
- busy asserts with the first SHIFT cycle and deasserts in the cycle IDLE is re-entered.

## Test plan
- Reset: hold reset 3 cycles with enable=1 -> adcSync=1, adcDataIn=0, sampleValid=0, sampleData=0, busy=0 every cycle. First adcSync low is on the cycle after reset releases.
- Framing, defaults: enable=1 for 5 frames -> adcSync low 16 cycles then high 4, period 20. Frame 0 shifts 0x8310|(0<<10). Frame 1 shifts 0x8710 (channel 1).
- Data capture: ADC model returns 0x0A5C for every frame -> no sampleValid in frame 0. sampleValid at c=16 of frame 1 with sampleData=12'hA5C, sampleChannel=0. Next strobe carries sampleChannel=1.
- Mask sequencing: CHANNEL_MASK=8'b1010_0101 -> addressed channels 0,2,5,7,0,2. sampleChannel sequence on strobes 0,2,5,7,0.
- Enable drop: deassert enable at c=5 of frame 3 -> frame 3 completes (16 bits, GAP, sampleValid at c=16), then IDLE with adcSync=1. Re-enable -> primer frame addresses channel 0 with no strobe.
- Reset mid-frame: assert reset at c=9 -> next edge: adcSync=1 and all outputs at reset values. No sampleValid for the aborted frame. The restart is a primer.
